// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender for the decode-to-operand path with valid/ready handshake on both sides.
// Optional macro IMM_EXTEND_ROTATE_EN enables ARM rotated-imm8 decoding for mode 00.
module imm_extend_pipe #(
  parameter int DATA_W     = 32,
  parameter int PIPE_DEPTH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       instr,
  input  logic [1:0]        imm_src,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_imm,
  output logic              carry_out
);

  localparam int LAST = PIPE_DEPTH - 1;

  logic [PIPE_DEPTH-1:0] stg_valid;
  logic [PIPE_DEPTH-1:0] stg_carry;
  logic [DATA_W-1:0]     stg_imm [PIPE_DEPTH];

  logic [PIPE_DEPTH-1:0] take;
  logic [PIPE_DEPTH-1:0] up_valid;
  logic [PIPE_DEPTH-1:0] up_carry;
  logic [DATA_W-1:0]     up_imm [PIPE_DEPTH];

  logic [DATA_W-1:0]     calc_imm;
  logic                  calc_carry;
  logic [31:0]           imm8_z;

`ifdef IMM_EXTEND_ROTATE_EN
  logic [5:0]            rot_amt;
  logic [31:0]           r32;
`endif

  assign imm8_z = {24'b0, instr[7:0]};

`ifdef IMM_EXTEND_ROTATE_EN
  assign rot_amt = {1'b0, instr[11:8], 1'b0};
  // A shift by 32 yields zero, so rot_amt==0 reduces to the unrotated value.
  assign r32     = (imm8_z >> rot_amt) | (imm8_z << (6'd32 - rot_amt));
`endif

  always_comb begin
    calc_imm   = '0;
    calc_carry = carry_in;
    case (imm_src)
      2'b00: begin
`ifdef IMM_EXTEND_ROTATE_EN
        calc_imm = DATA_W'(r32);
        if (instr[11:8] != 4'd0) calc_carry = r32[31];
`else
        calc_imm = DATA_W'(imm8_z);
`endif
      end
      2'b01:   calc_imm = DATA_W'(instr[11:0]);
      2'b10:   calc_imm = DATA_W'($signed({instr, 2'b00}));
      default: calc_imm = DATA_W'({instr[11:8], instr[3:0]});
    endcase
  end

  // Stage k can load when it or any later stage is empty, or the tail is draining.
  always_comb begin
    logic full_tail;
    full_tail = 1'b1;
    take      = '0;
    for (int k = LAST; k >= 0; k--) begin
      full_tail = full_tail & stg_valid[k];
      take[k]   = out_ready | ~full_tail;
    end
  end

  always_comb begin
    up_valid[0] = in_valid;
    up_carry[0] = calc_carry;
    up_imm[0]   = calc_imm;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      up_valid[k] = stg_valid[k-1];
      up_carry[k] = stg_carry[k-1];
      up_imm[k]   = stg_imm[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid <= '0;
      stg_carry <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) stg_imm[k] <= '0;
    end else begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        if (take[k]) begin
          stg_valid[k] <= up_valid[k];
          if (up_valid[k]) begin
            stg_imm[k]   <= up_imm[k];
            stg_carry[k] <= up_carry[k];
          end
        end
      end
    end
  end

  // Handshakes are masked during reset so nothing completes in the reset cycle.
  assign in_ready  = take[0] & ~reset;
  assign out_valid = stg_valid[LAST] & ~reset;
  assign ext_imm   = stg_imm[LAST];
  assign carry_out = stg_carry[LAST];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: a 32-bit depth-3 instance and a 64-bit depth-1 instance.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_in_valid, a_in_ready, a_cin, a_out_valid, a_out_ready, a_cout;
  logic [23:0] a_instr;
  logic [1:0]  a_src;
  logic [31:0] a_ext;
  logic        b_in_valid, b_in_ready, b_cin, b_out_valid, b_out_ready, b_cout;
  logic [23:0] b_instr;
  logic [1:0]  b_src;
  logic [63:0] b_ext;

  imm_extend_pipe #(.DATA_W(32), .PIPE_DEPTH(3)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .instr(a_instr), .imm_src(a_src), .carry_in(a_cin), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .ext_imm(a_ext), .carry_out(a_cout));

  imm_extend_pipe #(.DATA_W(64), .PIPE_DEPTH(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .instr(b_instr), .imm_src(b_src), .carry_in(b_cin), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .ext_imm(b_ext), .carry_out(b_cout));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] v;
    logic        c;
  } exp_t;

  typedef struct {
    logic [23:0] ins;
    logic [1:0]  src;
    logic        cin;
    logic [31:0] v;
    logic        c;
  } vec_t;

  exp_t q[$];

  // Reference: plain arithmetic on the field values.
  function automatic exp_t model(input logic [23:0] ins, input logic [1:0] src,
                                 input logic cin, input int w);
    exp_t e;
    longint unsigned x;
    longint s;
`ifdef IMM_EXTEND_ROTATE_EN
    int n;
`endif
    e.c = cin;
    case (src)
      2'd0: begin
        x = 64'(ins[7:0]);
`ifdef IMM_EXTEND_ROTATE_EN
        n = 2 * int'(ins[11:8]);
        if (n != 0) begin
          x   = ((x >> n) | (x << (32 - n))) & 64'hFFFF_FFFF;
          e.c = x[31];
        end
`endif
        e.v = x;
      end
      2'd1: e.v = 64'(ins[11:0]);
      2'd2: begin
        s = longint'(ins);
        if (ins[23]) s = s - (longint'(1) << 24);
        e.v = 64'(s * 4);
      end
      default: e.v = 64'(ins[11:8]) * 16 + 64'(ins[3:0]);
    endcase
    if (w == 32) e.v = e.v & 64'hFFFF_FFFF;
    return e;
  endfunction

  task automatic idle_inputs();
    a_in_valid = 0; a_instr = '0; a_src = '0; a_cin = 0; a_out_ready = 1;
    b_in_valid = 0; b_instr = '0; b_src = '0; b_cin = 0; b_out_ready = 1;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_ext !== 32'h0 || a_cout !== 1'b0 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_a: out_valid=%b ext=%h carry=%b in_ready=%b, want 0 0 0 1",
               a_out_valid, a_ext, a_cout, a_in_ready);
    end
    n_checks++;
    if (b_out_valid !== 1'b0 || b_ext !== 64'h0 || b_cout !== 1'b0 || b_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_b: out_valid=%b ext=%h carry=%b in_ready=%b, want 0 0 0 1",
               b_out_valid, b_ext, b_cout, b_in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t tbl[$];
    int lat;
    tbl.push_back('{24'hFFFFFE, 2'd2, 1'b0, 32'hFFFF_FFF8, 1'b0});
    tbl.push_back('{24'h000010, 2'd2, 1'b1, 32'h0000_0040, 1'b1});
    tbl.push_back('{24'h123ABC, 2'd1, 1'b1, 32'h0000_0ABC, 1'b1});
    tbl.push_back('{24'h000A05, 2'd3, 1'b0, 32'h0000_00A5, 1'b0});
`ifdef IMM_EXTEND_ROTATE_EN
    tbl.push_back('{24'h0004FF, 2'd0, 1'b0, 32'hFF00_0000, 1'b1});
`else
    tbl.push_back('{24'h0004FF, 2'd0, 1'b0, 32'h0000_00FF, 1'b0});
`endif
    tbl.push_back('{24'h0000FF, 2'd0, 1'b1, 32'h0000_00FF, 1'b1});
    foreach (tbl[i]) begin
      @(negedge clk);
      a_in_valid = 1; a_instr = tbl[i].ins; a_src = tbl[i].src; a_cin = tbl[i].cin;
      a_out_ready = 1;
      #1;
      n_checks++;
      if (a_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_in_ready[%0d]: got %b want 1", i, a_in_ready);
      end
      @(negedge clk);
      a_in_valid = 0;
      lat = 1;
      while (a_out_valid !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      n_checks++;
      if (lat != 3) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d cycles want 3", i, lat);
      end
      n_checks++;
      if (a_ext !== tbl[i].v || a_cout !== tbl[i].c) begin
        n_fail++;
        $display("FAIL directed_value[%0d]: got %h/%b want %h/%b", i, a_ext, a_cout,
                 tbl[i].v, tbl[i].c);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wide();
    int lat;
    @(negedge clk);
    b_in_valid = 1; b_instr = 24'hFFFFFE; b_src = 2'd2; b_cin = 1; b_out_ready = 1;
    @(negedge clk);
    b_in_valid = 0;
    lat = 1;
    while (b_out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 1 || b_ext !== 64'hFFFF_FFFF_FFFF_FFF8 || b_cout !== 1'b1) begin
      n_fail++;
      $display("FAIL wide_branch: lat=%0d ext=%h carry=%b, want 1 FFFFFFFFFFFFFFF8 1",
               lat, b_ext, b_cout);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0;
    bit prev_stall = 0, saw_full = 0;
    logic [31:0] prev_ext = '0;
    logic prev_c = 0;
    exp_t e;
    q.delete();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      a_in_valid = (sent < 6);
      a_instr = 24'($urandom); a_src = 2'($urandom); a_cin = 1'($urandom);
      a_out_ready = !(c >= 2 && c <= 7);
      #1;
      n_checks++;
      if (a_in_ready !== ((q.size() < 3) || a_out_ready)) begin
        n_fail++;
        $display("FAIL b2b_in_ready c=%0d: got %b want %b", c, a_in_ready,
                 (q.size() < 3) || a_out_ready);
      end
      if (a_in_ready === 1'b0) saw_full = 1;
      if (prev_stall) begin
        n_checks++;
        if (a_out_valid !== 1'b1 || a_ext !== prev_ext || a_cout !== prev_c) begin
          n_fail++;
          $display("FAIL b2b_stall_hold c=%0d: got %b/%h/%b want 1/%h/%b", c, a_out_valid,
                   a_ext, a_cout, prev_ext, prev_c);
        end
      end
      if (a_in_valid && a_in_ready) begin
        q.push_back(model(a_instr, a_src, a_cin, 32));
        sent++;
      end
      if (a_out_valid && a_out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_spurious c=%0d: got output %h want none", c, a_ext);
        end else begin
          e = q.pop_front();
          if (a_ext !== e.v[31:0] || a_cout !== e.c) begin
            n_fail++;
            $display("FAIL b2b_order c=%0d: got %h/%b want %h/%b", c, a_ext, a_cout,
                     e.v[31:0], e.c);
          end
        end
        got++;
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_ext = a_ext;
      prev_c = a_cout;
    end
    a_in_valid = 0;
    n_checks++;
    if (got != 6 || q.size() != 0 || !saw_full) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d outputs, %0d left, full_seen=%0d; want 6 0 1",
               got, q.size(), saw_full);
    end
  endtask

  task automatic test_random();
    bit prev_stall = 0;
    logic [31:0] prev_ext = '0;
    logic prev_c = 0;
    exp_t e;
    q.delete();
    for (int c = 0; c < 330; c++) begin
      @(negedge clk);
      a_in_valid  = (c < 300) && ($urandom_range(0, 3) != 0);
      a_instr     = 24'($urandom); a_src = 2'($urandom); a_cin = 1'($urandom);
      a_out_ready = (c >= 300) || ($urandom_range(0, 2) != 0);
      #1;
      n_checks++;
      if (a_in_ready !== ((q.size() < 3) || a_out_ready)) begin
        n_fail++;
        $display("FAIL rnd_in_ready c=%0d: got %b want %b", c, a_in_ready,
                 (q.size() < 3) || a_out_ready);
      end
      if (prev_stall) begin
        n_checks++;
        if (a_out_valid !== 1'b1 || a_ext !== prev_ext || a_cout !== prev_c) begin
          n_fail++;
          $display("FAIL rnd_stall_hold c=%0d: got %b/%h want 1/%h", c, a_out_valid,
                   a_ext, prev_ext);
        end
      end
      if (a_in_valid && a_in_ready) q.push_back(model(a_instr, a_src, a_cin, 32));
      if (a_out_valid && a_out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_spurious c=%0d: got output %h want none", c, a_ext);
        end else begin
          e = q.pop_front();
          if (a_ext !== e.v[31:0] || a_cout !== e.c) begin
            n_fail++;
            $display("FAIL rnd_value c=%0d: got %h/%b want %h/%b", c, a_ext, a_cout,
                     e.v[31:0], e.c);
          end
        end
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_ext = a_ext;
      prev_c = a_cout;
    end
    a_in_valid = 0;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_drain: got %0d results still missing want 0", q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a_in_valid = 1; a_instr = 24'h000A05 + 24'(i); a_src = 2'd3; a_out_ready = 1;
      #1;
      n_checks++;
      if (a_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst_accept[%0d]: got in_ready %b want 1", i, a_in_ready);
      end
    end
    @(negedge clk);
    a_in_valid = 0;
    reset = 1;
    #1;
    n_checks++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_during: got out_valid %b want 0", a_out_valid);
    end
    @(negedge clk);
    reset = 0;
    #1;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_ext !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_after: got %b/%h want 0/00000000", a_out_valid, a_ext);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_out_valid !== 1'b0) stale++;
    end
    n_checks++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL midrst_stale: got %0d stale outputs want 0", stale);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_wide();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
